ram_dp_be: RTL and testbench

Parametrised successor to the single-port 32-bit RAM. It has one write port and one read port, per-byte write strobes, and byte addressing. Reads are registered and return a valid flag; a read-during-write collision is resolved according to a selectable mode. An optional post-reset clear sequencer zeroes the whole array and reports busy while it runs. The block is the data/instruction memory behind the core's load/store unit.

---
 rtl/ram_pkg.sv | 30 +++
 rtl/ram_dp_be_if.sv | 29 ++
 rtl/ram_clear_seq.sv | 52 +++++
 rtl/ram_dp_be.sv | 115 +++++++++++
 tb/tb_ram_dp_be.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM.
// Included by the RAM top, its clear sequencer and its users.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word merge_bytes can handle; callers size-cast in and out.
  localparam int MAX_DW = 256;
  localparam int MAX_SW = MAX_DW / 8;

  typedef enum logic {
    CLEAR,
    IDLE
  } ram_clr_state_t;

  function automatic logic [MAX_DW-1:0] merge_bytes(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_SW-1:0] strb
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int k = 0; k < MAX_SW; k++) begin
      if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_dp_be_if.sv
// Write/read bus of the dual-port byte-enable RAM.
// master drives requests, slave is the memory.
interface ram_dp_be_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          we_i;
  logic [DW/8-1:0] wstrb_i;
  logic [AW-1:0] waddr_i;
  logic [DW-1:0] wdata_i;
  logic          re_i;
  logic [AW-1:0] raddr_i;
  logic [DW-1:0] rdata_o;
  logic          rvalid_o;
  logic          busy_o;
  logic          err_o;

  modport master (
    output we_i, wstrb_i, waddr_i, wdata_i,
    output re_i, raddr_i,
    input  rdata_o, rvalid_o, busy_o, err_o
  );

  modport slave (
    input  we_i, wstrb_i, waddr_i, wdata_i,
    input  re_i, raddr_i,
    output rdata_o, rvalid_o, busy_o, err_o
  );
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word index once,
// asserting a zero-write per cycle, then idles.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int IW           = 10,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [IW-1:0] clr_idx
);

  ram_clr_state_t state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? CLEAR : IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      IDLE: ;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == CLEAR);
  assign clr_idx = idx_q;

endmodule

// File: rtl/ram_dp_be.sv
// One-write/one-read RAM with byte strobes, byte addressing,
// registered reads, selectable read-during-write and auto-clear.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int DW           = 32,
  parameter int DEPTH        = 1024,
  parameter int AW           = 32,
  parameter int RDW_MODE     = RDW_READ_FIRST,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input logic        clk,
  input logic        rst,
  ram_dp_be_if.slave bus
);

  localparam int SW = DW / 8;
  localparam int BW = $clog2(SW);
  localparam int IW = $clog2(DEPTH);

  if (DW % 8 != 0) begin : g_dw_chk
    $error("ram_dp_be: DW must be a multiple of 8");
  end
  if (DW > MAX_DW) begin : g_dw_max
    $error("ram_dp_be: DW exceeds MAX_DW");
  end
  if (DEPTH < 2) begin : g_depth_chk
    $error("ram_dp_be: DEPTH must be at least 2");
  end
  if (AW < $clog2(DEPTH * SW)) begin : g_aw_chk
    $error("ram_dp_be: AW too narrow for DEPTH");
  end

  logic [DW-1:0] mem [DEPTH];

  logic          busy, clr_we;
  logic [IW-1:0] clr_idx;

  ram_clear_seq #(
    .DEPTH        (DEPTH),
    .IW           (IW),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // Full-width indices so the range compare sees every address bit.
  logic [AW-1:0] wfull, rfull;
  logic          w_in, r_in;
  logic [IW-1:0] widx, ridx;
  logic          w_act, wr_ok, rd_req, err_d;
  logic [DW-1:0] rd_word, fwd_word;

  assign wfull = bus.waddr_i >> BW;
  assign rfull = bus.raddr_i >> BW;
  assign w_in  = wfull < AW'(DEPTH);
  assign r_in  = rfull < AW'(DEPTH);
  assign widx  = wfull[IW-1:0];
  assign ridx  = rfull[IW-1:0];

  assign w_act  = !busy && bus.we_i && (|bus.wstrb_i);
  assign wr_ok  = w_act && w_in;
  assign rd_req = !busy && bus.re_i;
  assign err_d  = (w_act && !w_in) || (rd_req && !r_in);

  assign fwd_word = DW'(merge_bytes(
    MAX_DW'(mem[ridx]), MAX_DW'(bus.wdata_i),
    MAX_SW'(bus.wstrb_i)));

  always_comb begin
    rd_word = mem[ridx];
    if (!r_in) begin
      rd_word = '0;
    end else if (RDW_MODE == RDW_WRITE_FIRST &&
                 wr_ok && ridx == widx) begin
      rd_word = fwd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < SW; k++) begin
        if (bus.wstrb_i[k])
          mem[widx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
      end
    end
  end

  logic [DW-1:0] rdata_q;
  logic          rvalid_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_req;
      err_q    <= err_d;
      if (rd_req) rdata_q <= rd_word;
    end
  end

  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = busy;

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench: read-first and write-first RAMs side by side,
// plus a no-clear instance for the reset-state check.
module tb_ram_dp_be;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic        we, re;
  logic [3:0]  strb;
  logic [31:0] waddr, wdata, raddr;

  ram_dp_be_if #(.DW(32), .AW(32)) if0 ();
  ram_dp_be_if #(.DW(32), .AW(32)) if1 ();
  ram_dp_be_if #(.DW(32), .AW(32)) if2 ();

  assign if0.we_i = we;    assign if1.we_i = we;    assign if2.we_i = we;
  assign if0.re_i = re;    assign if1.re_i = re;    assign if2.re_i = re;
  assign if0.wstrb_i = strb; assign if1.wstrb_i = strb; assign if2.wstrb_i = strb;
  assign if0.waddr_i = waddr; assign if1.waddr_i = waddr; assign if2.waddr_i = waddr;
  assign if0.wdata_i = wdata; assign if1.wdata_i = wdata; assign if2.wdata_i = wdata;
  assign if0.raddr_i = raddr; assign if1.raddr_i = raddr; assign if2.raddr_i = raddr;

  ram_dp_be #(.DW(32), .DEPTH(16), .AW(32),
    .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RST(1'b1))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  ram_dp_be #(.DW(32), .DEPTH(16), .AW(32),
    .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RST(1'b1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  ram_dp_be #(.DW(32), .DEPTH(16), .AW(32),
    .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RST(1'b0))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] raddr;
    logic        rv;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        err;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] exp_mem [16];
  logic [31:0] last0, last1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] s,
                       input logic [31:0] wa, input logic [31:0] wd,
                       input logic r, input logic [31:0] ra);
    we = w; strb = s; waddr = wa; wdata = wd; re = r; raddr = ra;
  endtask

  function automatic vec_t mk(
    input logic w, input logic [3:0] s, input logic [31:0] wa,
    input logic [31:0] wd, input logic r, input logic [31:0] ra,
    input logic rv, input logic [31:0] d0, input logic [31:0] d1,
    input logic e);
    vec_t v;
    v.we = w; v.strb = s; v.waddr = wa; v.wdata = wd;
    v.re = r; v.raddr = ra; v.rv = rv; v.d0 = d0; v.d1 = d1;
    v.err = e;
    return v;
  endfunction

  // Reads every word back-to-back against exp_mem.
  task automatic scan(input string nm);
    for (int i = 0; i < 16; i++) begin
      drive(0, 4'h0, 0, 0, 1, 32'(4 * i));
      @(posedge clk); @(negedge clk);
      chk({nm, "_rv0"}, 32'(if0.rvalid_o), 1);
      chk({nm, "_rv1"}, 32'(if1.rvalid_o), 1);
      chk($sformatf("%s_d0[%0d]", nm, i), if0.rdata_o, exp_mem[i]);
      chk($sformatf("%s_d1[%0d]", nm, i), if1.rdata_o, exp_mem[i]);
    end
    drive(0, 4'h0, 0, 0, 0, 0);
    last0 = exp_mem[15];
    last1 = exp_mem[15];
  endtask

  // Counts negedge samples with busy high; injects a write+read
  // on the fourth busy cycle, which must be ignored.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!if0.busy_o) break;
      n++;
      if (n == 4) drive(1, 4'hF, 32'h4, 32'hFFFF_FFFF, 1, 32'h4);
      else drive(0, 4'h0, 0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      if (n == 4) begin
        chk("busy_rv0", 32'(if0.rvalid_o), 0);
        chk("busy_rv1", 32'(if1.rvalid_o), 0);
        chk("busy_err0", 32'(if0.err_o), 0);
      end
    end
    drive(0, 4'h0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    drive(0, 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;

    vt.push_back(mk(1, 4'hF, 32'h04, 32'hAAAA_AAAA, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'h2, 32'h04, 32'h0000_CD00, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h04, 1, 32'hAAAA_CDAA, 32'hAAAA_CDAA, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h05, 1, 32'hAAAA_CDAA, 32'hAAAA_CDAA, 0));
    vt.push_back(mk(1, 4'hF, 32'h08, 32'h1111_1111, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'hF, 32'h08, 32'h2222_2222, 1, 32'h08, 1, 32'h1111_1111, 32'h2222_2222, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h08, 1, 32'h2222_2222, 32'h2222_2222, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h40, 1, 32'h0, 32'h0, 1));
    vt.push_back(mk(1, 4'hF, 32'h40, 32'h1234_5678, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 4'h0, 32'h0C, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h0C, 1, 32'h0, 32'h0, 0));
    vt.push_back(mk(1, 4'hF, 32'h44, 32'h5555_5555, 1, 32'h48, 1, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h00, 1, 32'h0, 32'h0, 0));
    vt.push_back(mk(1, 4'hF, 32'h10, 32'hCAFE_F00D, 1, 32'h14, 1, 32'h0, 32'h0, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h10, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'h9, 32'h10, 32'h1122_3344, 1, 32'h10, 1, 32'hCAFE_F00D, 32'h11FE_F044, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h10, 1, 32'h11FE_F044, 32'h11FE_F044, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h00, 1, 32'h0, 32'h0, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h04, 1, 32'hAAAA_CDAA, 32'hAAAA_CDAA, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 1, 32'h08, 1, 32'h2222_2222, 32'h2222_2222, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));

    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_rdata0", if0.rdata_o, 0);
    chk("rst_rvalid0", 32'(if0.rvalid_o), 0);
    chk("rst_err0", 32'(if0.err_o), 0);
    chk("rst_busy0", 32'(if0.busy_o), 1);
    chk("rst_busy1", 32'(if1.busy_o), 1);
    chk("rst_busy_noclr", 32'(if2.busy_o), 0);
    rst = 1'b0;

    count_busy(n);
    chk("clear_cycles", 32'(n), 16);
    chk("busy1_done", 32'(if1.busy_o), 0);
    scan("clr");

    foreach (vt[i]) begin
      drive(vt[i].we, vt[i].strb, vt[i].waddr, vt[i].wdata,
            vt[i].re, vt[i].raddr);
      @(posedge clk); @(negedge clk);
      if (vt[i].rv) begin
        last0 = vt[i].d0;
        last1 = vt[i].d1;
      end
      chk($sformatf("v%0d_rv0", i), 32'(if0.rvalid_o), 32'(vt[i].rv));
      chk($sformatf("v%0d_rv1", i), 32'(if1.rvalid_o), 32'(vt[i].rv));
      chk($sformatf("v%0d_d0", i), if0.rdata_o, last0);
      chk($sformatf("v%0d_d1", i), if1.rdata_o, last1);
      chk($sformatf("v%0d_err0", i), 32'(if0.err_o), 32'(vt[i].err));
      chk($sformatf("v%0d_err1", i), 32'(if1.err_o), 32'(vt[i].err));
    end
    drive(0, 4'h0, 0, 0, 0, 0);

    exp_mem[1] = 32'hAAAA_CDAA;
    exp_mem[2] = 32'h2222_2222;
    exp_mem[4] = 32'h11FE_F044;
    scan("post");

    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(if0.busy_o), 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_busy", 32'(if0.busy_o), 1);
    rst = 1'b0;
    count_busy(n);
    chk("reclear_cycles", 32'(n), 16);
    chk("noclr_busy", 32'(if2.busy_o), 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    scan("reclr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
